// File: rtl/fpu_add_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : fpu_add_dispatch
// Brief    : Request FIFO and dispatch FSM that feeds a multi-cycle FP adder
//            and holds each result until it is consumed.
// Option   : FPU_DISPATCH_TIMEOUT_EN adds a WAIT timeout (TIMEOUT cycles)
//            that returns a quiet NaN with rsp_err set.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_add_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_a,
    input  logic [31:0]              req_b,
    input  logic                     req_sub,
    output logic [31:0]              fpu_a,
    output logic [31:0]              fpu_b,
    output logic                     fpu_sub,
    output logic                     fpu_enable,
    input  logic [31:0]              fpu_result,
    input  logic                     fpu_result_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 65;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q;

    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     wr_ptr_d;
    logic [AW:0]     rd_ptr_q;
    logic [AW:0]     rd_ptr_d;
    logic [EW-1:0]   mem_q [DEPTH];

    logic [31:0]     fpu_a_q;
    logic [31:0]     fpu_b_q;
    logic            fpu_sub_q;
    logic            fpu_enable_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_data_q;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [EW-1:0]   w_head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_push  = req_valid && !w_full;
    assign w_pop   = (state_q == IDLE) && !w_empty;
    assign w_head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {req_a, req_b, req_sub};
        end
    end

`ifdef FPU_DISPATCH_TIMEOUT_EN
    localparam int          CW              = $clog2(TIMEOUT + 1);
    localparam logic [31:0] c_timeout_nan   = 32'hFFC00000;

    logic [CW-1:0]   tmo_cnt_q;
    logic            rsp_err_q;
`else
    logic            unused_cfg;
    assign unused_cfg = (TIMEOUT > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
            fpu_sub_q    <= 1'b0;
            fpu_enable_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
`ifdef FPU_DISPATCH_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!w_empty) begin
                        {fpu_a_q, fpu_b_q, fpu_sub_q} <= w_head;
                        fpu_enable_q                  <= 1'b1;
                        state_q                       <= ISSUE;
                    end
                end
                ISSUE: begin
                    fpu_enable_q <= 1'b0;
                    state_q      <= WAIT;
`ifdef FPU_DISPATCH_TIMEOUT_EN
                    tmo_cnt_q    <= '0;
`endif
                end
                WAIT: begin
                    // Operands stay untouched here; the adder re-reads them.
                    if (fpu_result_ready) begin
                        rsp_data_q  <= fpu_result;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
`ifdef FPU_DISPATCH_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (tmo_cnt_q == CW'(TIMEOUT - 1)) begin
                        // TIMEOUT full WAIT cycles elapsed without a result.
                        rsp_data_q  <= c_timeout_nan;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        tmo_cnt_q   <= tmo_cnt_q + CW'(1);
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = !w_full;
    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fpu_a      = fpu_a_q;
    assign fpu_b      = fpu_b_q;
    assign fpu_sub    = fpu_sub_q;
    assign fpu_enable = fpu_enable_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
`ifdef FPU_DISPATCH_TIMEOUT_EN
    assign rsp_err    = rsp_err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_add_dispatch.sv
`default_nettype none
// Scoreboard bench for fpu_add_dispatch with a table-driven adder stub.
module tb_fpu_add_dispatch;

`ifdef FPU_DISPATCH_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        req_sub = 1'b0;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic        fpu_sub;
    logic        fpu_enable;
    logic [31:0] fpu_result = '0;
    logic        fpu_result_ready = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [2:0]  fifo_count;

    int          checks = 0;
    int          errors = 0;
    int          n_enable = 0;
    int          n_acc = 0;
    int          rst_gen = 0;
    int          stub_lat = 2;
    bit          stub_silent = 1'b0;
    bit          prev_en = 1'b0;
    logic [32:0] sb [$];

    fpu_add_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sub(fpu_sub), .fpu_enable(fpu_enable),
        .fpu_result(fpu_result), .fpu_result_ready(fpu_result_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(negedge rst_n) rst_gen++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hand-computed single-precision results for every vector used.
    function automatic logic [31:0] fp_lookup(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
        case ({a, b, s})
            {32'h3F800000, 32'h40000000, 1'b0}: fp_lookup = 32'h40400000;
            {32'h40400000, 32'h3F800000, 1'b1}: fp_lookup = 32'h40000000;
            {32'h40000000, 32'h40000000, 1'b1}: fp_lookup = 32'h00000000;
            {32'h3F800000, 32'h3F800000, 1'b0}: fp_lookup = 32'h40000000;
            {32'h40000000, 32'h40000000, 1'b0}: fp_lookup = 32'h40800000;
            {32'h40400000, 32'h3F800000, 1'b0}: fp_lookup = 32'h40800000;
            {32'h40800000, 32'h3F800000, 1'b1}: fp_lookup = 32'h40400000;
            {32'h3F800000, 32'h40000000, 1'b1}: fp_lookup = 32'hBF800000;
            {32'h40000000, 32'h3F800000, 1'b0}: fp_lookup = 32'h40400000;
            default:                            fp_lookup = 32'hDEADBEEF;
        endcase
    endfunction

    // Adder stub: answers each start strobe after stub_lat cycles.
    initial begin
        logic [31:0] ca, cb;
        logic        cs;
        int          g;
        forever begin
            @(posedge clk); #1;
            if (rst_n && fpu_enable && !stub_silent) begin
                ca = fpu_a; cb = fpu_b; cs = fpu_sub; g = rst_gen;
                repeat (stub_lat) @(posedge clk);
                #1;
                fpu_result       = fp_lookup(ca, cb, cs);
                fpu_result_ready = 1'b1;
                if (g == rst_gen) begin
                    chk("operands_stable", {fpu_a ^ ca} | {fpu_b ^ cb} | 32'(fpu_sub ^ cs), 32'h0);
                end
                @(posedge clk); #1;
                fpu_result_ready = 1'b0;
            end
        end
    end

    // Monitor: strobe width and in-order responses against the scoreboard.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n) begin
            if (fpu_enable) begin
                n_enable++;
                chk("enable_one_cycle", 32'(prev_en), 32'h0);
            end
            prev_en = fpu_enable;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got data %h err %0d, required none", rsp_data, rsp_err);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_data", rsp_data, e[32:1]);
                    chk("rsp_err", 32'(rsp_err), 32'(e[0]));
                end
            end
        end else begin
            prev_en = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit acc_exp, input logic [31:0] res, input logic err);
        bit acc;
        req_valid = 1'b1; req_a = a; req_b = b; req_sub = s;
        @(negedge clk);
        acc = req_ready;
        chk("push_accept", 32'(acc), 32'(acc_exp));
        if (acc) begin
            sb.push_back({res, err});
            n_acc++;
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int i;
        for (i = 0; i < 100; i++) begin
            if (rsp_valid) break;
            tick();
        end
        chk("rsp_arrives", 32'(rsp_valid), 32'h1);
    endtask

    task automatic release_one();
        wait_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic wait_enable();
        int i;
        for (i = 0; i < 50; i++) begin
            if (fpu_enable) break;
            tick();
        end
        chk("enable_arrives", 32'(fpu_enable), 32'h1);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 400; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_fpu_enable"}, 32'(fpu_enable), 32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_data"}, rsp_data, 32'h0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
        chk({tag, "_fpu_a"}, fpu_a, 32'h0);
        chk({tag, "_fpu_b"}, fpu_b, 32'h0);
        chk({tag, "_fpu_sub"}, 32'(fpu_sub), 32'h0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'h1);
        chk({tag, "_fifo_count"}, 32'(fifo_count), 32'h0);
    endtask

    initial begin
        #1;
        check_reset("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic add, accepted on the first edge after reset release.
        rsp_ready = 1'b1;
        push(32'h3F800000, 32'h40000000, 1'b0, 1'b1, 32'h40400000, 1'b0);
        drain();
        push(32'h40400000, 32'h3F800000, 1'b1, 1'b1, 32'h40000000, 1'b0);
        push(32'h40000000, 32'h40000000, 1'b1, 1'b1, 32'h00000000, 1'b0);
        drain();

        // Fill with responses blocked: one in the adder, four queued, sixth dropped.
        rsp_ready = 1'b0;
        push(32'h3F800000, 32'h3F800000, 1'b0, 1'b1, 32'h40000000, 1'b0);
        push(32'h40000000, 32'h40000000, 1'b0, 1'b1, 32'h40800000, 1'b0);
        push(32'h40400000, 32'h3F800000, 1'b0, 1'b1, 32'h40800000, 1'b0);
        push(32'h40800000, 32'h3F800000, 1'b1, 1'b1, 32'h40400000, 1'b0);
        push(32'h3F800000, 32'h40000000, 1'b1, 1'b1, 32'hBF800000, 1'b0);
        push(32'h40000000, 32'h3F800000, 1'b0, 1'b0, 32'h40400000, 1'b0);
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_ready", 32'(req_ready), 32'h0);
        release_one();
        // IDLE pop with a push offered while full: push must be dropped.
        push(32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'h40400000, 1'b0);
        chk("pop_when_full_count", 32'(fifo_count), 32'd3);
        rsp_ready = 1'b1;
        drain();

        // Simultaneous push and pop at occupancy 2.
        rsp_ready = 1'b0;
        push(32'h3F800000, 32'h40000000, 1'b0, 1'b1, 32'h40400000, 1'b0);
        push(32'h40400000, 32'h3F800000, 1'b1, 1'b1, 32'h40000000, 1'b0);
        push(32'h40000000, 32'h40000000, 1'b1, 1'b1, 32'h00000000, 1'b0);
        chk("count_two", 32'(fifo_count), 32'd2);
        release_one();
        push(32'h40000000, 32'h3F800000, 1'b0, 1'b1, 32'h40400000, 1'b0);
        chk("push_pop_count", 32'(fifo_count), 32'd2);
        chk("push_pop_issue", 32'(fpu_enable), 32'h1);
        rsp_ready = 1'b1;
        drain();

        // Asynchronous reset while waiting on the adder; its late pulse is stale.
        stub_lat = 3;
        push(32'h3F800000, 32'h40000000, 1'b0, 1'b1, 32'h40400000, 1'b0);
        wait_enable();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stale_pulse_ignored", 32'(rsp_valid), 32'h0);
            tick();
        end
        stub_lat = 2;

`ifdef FPU_DISPATCH_TIMEOUT_EN
        begin
            int cyc;
            stub_silent = 1'b1;
            push(32'h40400000, 32'h3F800000, 1'b1, 1'b1, 32'hFFC00000, 1'b1);
            wait_enable();
            cyc = 0;
            while (!rsp_valid && cyc < 100) begin
                tick();
                cyc++;
            end
            chk("timeout_latency", cyc, TMO + 1);
            drain();
            stub_silent = 1'b0;
            push(32'h40000000, 32'h40000000, 1'b1, 1'b1, 32'h00000000, 1'b0);
            drain();
        end
`endif

        repeat (3) tick();
        chk("issue_count", n_enable, n_acc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
